// File: rtl/blackjack_turn_controller.sv
// Sequences one blackjack hand: opening deal, gated player turn with key-release
// debounce, dealer draw-to-threshold turn and final result.
package blackjack_pkg;
  typedef enum logic [1:0] {
    COMMAND_NONE  = 2'd0,
    COMMAND_HIT   = 2'd1,
    COMMAND_STAND = 2'd2
  } gameCommand;
endpackage

module blackjack_turn_controller
  import blackjack_pkg::*;
#(
  parameter int unsigned DEALER_STAND   = 17,
  parameter int unsigned RELEASE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       player_ready,
  input  gameCommand player_command,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic       card_req,
  output logic       turn_indicator,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [1:0] result,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL_P, PLAYER_TURN, PLAYER_HIT,
    WAIT_RELEASE, DEALER_TURN, DEALER_HIT, RESOLVE, DONE
  } state_t;

  localparam logic [4:0]  STAND_LIMIT   = 5'(DEALER_STAND);
  localparam logic [15:0] RELEASE_LIMIT = 16'(RELEASE_CYCLES);

  function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
    if (ace && hard <= 5'd11) return hard + 5'd10;
    return hard;
  endfunction

  function automatic logic [4:0] card_points(input logic [3:0] v);
    if (v >= 4'd1 && v <= 4'd10) return {1'b0, v};
    return 5'd10;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic        p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [4:0]  p_total_q, p_total_d, d_total_q, d_total_d;
  logic [1:0]  result_q, result_d;
  logic        done_q, done_d;
  logic        card_req_q, card_req_d;
  logic        turn_q, turn_d;
  logic [15:0] rel_cnt_q, rel_cnt_d;
  logic        pend_dealer_q, pend_dealer_d;

  logic       accept, add_player, add_dealer, card_is_ace;
  logic [4:0] pts, p_best, d_best;

  always_comb begin
    state_d       = state_q;
    p_hard_d      = p_hard_q;
    p_ace_d       = p_ace_q;
    d_hard_d      = d_hard_q;
    d_ace_d       = d_ace_q;
    result_d      = result_q;
    done_d        = done_q;
    card_req_d    = card_req_q;
    rel_cnt_d     = rel_cnt_q;
    pend_dealer_d = pend_dealer_q;
    add_player    = 1'b0;
    add_dealer    = 1'b0;
    accept        = card_req_q && card_valid;
    pts           = card_points(card_value);
    card_is_ace   = (card_value == 4'd1);
    p_best        = best_total(p_hard_q, p_ace_q);
    d_best        = best_total(d_hard_q, d_ace_q);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          p_hard_d   = 5'd0;
          p_ace_d    = 1'b0;
          d_hard_d   = 5'd0;
          d_ace_d    = 1'b0;
          result_d   = 2'd0;
          done_d     = 1'b0;
          card_req_d = 1'b1;
          state_d    = DEAL_P1;
        end
      end
      DEAL_P1: begin
        card_req_d = !accept;
        if (accept) begin
          add_player = 1'b1;
          state_d    = DEAL_D1;
        end
      end
      DEAL_D1: begin
        card_req_d = !accept;
        if (accept) begin
          add_dealer = 1'b1;
          state_d    = DEAL_P2;
        end
      end
      DEAL_P2: begin
        card_req_d = !accept;
        if (accept) begin
          add_player = 1'b1;
          state_d    = DEAL_D2;
        end
      end
      DEAL_D2: begin
        card_req_d = !accept;
        if (accept) begin
          add_dealer = 1'b1;
          state_d    = EVAL_P;
        end
      end
      EVAL_P: begin
        if (p_best == 5'd21)     state_d = DEALER_TURN;
        else if (p_best > 5'd21) state_d = RESOLVE;
        else                     state_d = PLAYER_TURN;
      end
      PLAYER_TURN: begin
        if (player_ready) begin
          if (player_command == COMMAND_HIT) begin
            pend_dealer_d = 1'b0;
            card_req_d    = 1'b1;
            state_d       = PLAYER_HIT;
          end else if (player_command == COMMAND_STAND) begin
            pend_dealer_d = 1'b1;
            rel_cnt_d     = 16'd0;
            state_d       = WAIT_RELEASE;
          end
        end
      end
      PLAYER_HIT: begin
        card_req_d = !accept;
        if (accept) begin
          add_player = 1'b1;
          rel_cnt_d  = 16'd0;
          state_d    = WAIT_RELEASE;
        end
      end
      // A held key keeps the counter at zero, so one press yields one action.
      WAIT_RELEASE: begin
        if (rel_cnt_q == RELEASE_LIMIT) begin
          rel_cnt_d = 16'd0;
          state_d   = pend_dealer_q ? DEALER_TURN : EVAL_P;
        end else if (player_ready) begin
          rel_cnt_d = 16'd0;
        end else begin
          rel_cnt_d = rel_cnt_q + 16'd1;
        end
      end
      DEALER_TURN: begin
        if (d_best < STAND_LIMIT) begin
          card_req_d = 1'b1;
          state_d    = DEALER_HIT;
        end else begin
          state_d = RESOLVE;
        end
      end
      DEALER_HIT: begin
        card_req_d = !accept;
        if (accept) begin
          add_dealer = 1'b1;
          state_d    = DEALER_TURN;
        end
      end
      RESOLVE: begin
        if (p_best > 5'd21)       result_d = 2'd2;
        else if (d_best > 5'd21)  result_d = 2'd1;
        else if (p_best > d_best) result_d = 2'd1;
        else if (p_best < d_best) result_d = 2'd2;
        else                      result_d = 2'd3;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: begin
        card_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

    if (add_player) begin
      p_hard_d = p_hard_q + pts;
      p_ace_d  = p_ace_q | card_is_ace;
    end
    if (add_dealer) begin
      d_hard_d = d_hard_q + pts;
      d_ace_d  = d_ace_q | card_is_ace;
    end

    p_total_d = best_total(p_hard_d, p_ace_d);
    d_total_d = best_total(d_hard_d, d_ace_d);
    // A key still down from the previous turn must be released before the window reopens.
    turn_d    = (state_d == PLAYER_TURN) && !((state_q == PLAYER_TURN) && player_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      p_hard_q      <= 5'd0;
      p_ace_q       <= 1'b0;
      d_hard_q      <= 5'd0;
      d_ace_q       <= 1'b0;
      p_total_q     <= 5'd0;
      d_total_q     <= 5'd0;
      result_q      <= 2'd0;
      done_q        <= 1'b0;
      card_req_q    <= 1'b0;
      turn_q        <= 1'b0;
      rel_cnt_q     <= 16'd0;
      pend_dealer_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_hard_q      <= p_hard_d;
      p_ace_q       <= p_ace_d;
      d_hard_q      <= d_hard_d;
      d_ace_q       <= d_ace_d;
      p_total_q     <= p_total_d;
      d_total_q     <= d_total_d;
      result_q      <= result_d;
      done_q        <= done_d;
      card_req_q    <= card_req_d;
      turn_q        <= turn_d;
      rel_cnt_q     <= rel_cnt_d;
      pend_dealer_q <= pend_dealer_d;
    end
  end

  assign card_req       = card_req_q;
  assign turn_indicator = turn_q;
  assign player_total   = p_total_q;
  assign dealer_total   = d_total_q;
  assign result         = result_q;
  assign done           = done_q;

endmodule

// File: tb/tb_blackjack_turn_controller.sv
// Self-checking bench for blackjack_turn_controller: table of directed hands,
// handshake corner sequences and randomized hands against a card-list model.
module tb_blackjack_turn_controller;
  import blackjack_pkg::*;

  localparam int RC = 8;

  logic       clk = 1'b0;
  logic       reset, start, player_ready, card_valid;
  gameCommand player_command;
  logic [3:0] card_value;
  logic       card_req, turn_indicator, done;
  logic [4:0] player_total, dealer_total;
  logic [1:0] result;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] deck[$];
  bit         server_en = 1'b0;
  int         accepted  = 0;
  int         turn_rises = 0;
  logic       turn_prev = 1'b0;

  typedef struct packed {
    logic [31:0] cards;
    logic [3:0]  n_cards;
    logic [1:0]  cmd;
    logic [1:0]  n_cmds;
    logic [7:0]  hold;
    logic [4:0]  exp_p;
    logic [4:0]  exp_d;
    logic [1:0]  exp_res;
  } hand_vec_t;

  hand_vec_t vecs[8];

  blackjack_turn_controller #(.DEALER_STAND(17), .RELEASE_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .player_ready(player_ready),
    .player_command(player_command), .card_valid(card_valid), .card_value(card_value),
    .card_req(card_req), .turn_indicator(turn_indicator), .player_total(player_total),
    .dealer_total(dealer_total), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  // Cards leave the deck only on a real handshake.
  always @(posedge clk) begin
    if (!reset && card_req && card_valid) begin
      accepted++;
      if (deck.size() > 0) void'(deck.pop_front());
    end
  end

  // Card source with random latency and noise on card_valid while no request is pending.
  always @(negedge clk) begin
    if (server_en) begin
      card_valid = 1'b0;
      card_value = 4'($urandom_range(0, 15));
      if (card_req && deck.size() > 0) begin
        if ($urandom_range(0, 3) != 0) begin
          card_valid = 1'b1;
          card_value = deck[0];
        end
      end else if (!card_req) begin
        card_valid = 1'($urandom_range(0, 1));
      end
    end
  end

  always @(negedge clk) begin
    if (turn_indicator && !turn_prev) turn_rises++;
    turn_prev = turn_indicator;
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic start_hand();
    accepted   = 0;
    turn_rises = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_player(input logic [63:0] cmds, input int n, input int hold,
                            input bit jitter, input string tag);
    for (int k = 0; k < n; k++) begin
      int budget;
      budget = 0;
      while (!turn_indicator && budget < 300) begin
        @(negedge clk);
        budget++;
      end
      if (!turn_indicator) begin
        checkOutput({tag, " turn_timeout"}, 0, 1);
        return;
      end
      player_ready   = 1'b1;
      player_command = gameCommand'(cmds[k*4 +: 2]);
      if (jitter && $urandom_range(0, 3) == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < hold; c++) @(negedge clk);
      player_ready   = 1'b0;
      player_command = COMMAND_NONE;
      if (jitter && $urandom_range(0, 1) == 1) begin
        repeat (2) @(negedge clk);
        player_ready   = 1'b1;
        player_command = COMMAND_HIT;
        @(negedge clk);
        player_ready   = 1'b0;
        player_command = COMMAND_NONE;
      end
    end
  endtask

  task automatic check_hand(input string tag, input int ep, input int ed, input int er,
                            input int eused, input int eturns);
    int budget;
    budget = 0;
    while (!done && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, " done"}, int'(done), 1);
    checkOutput({tag, " player_total"}, int'(player_total), ep);
    checkOutput({tag, " dealer_total"}, int'(dealer_total), ed);
    checkOutput({tag, " result"}, int'(result), er);
    checkOutput({tag, " cards_accepted"}, accepted, eused);
    checkOutput({tag, " turn_windows"}, turn_rises, eturns);
    checkOutput({tag, " card_req_after_done"}, int'(card_req), 0);
  endtask

  task automatic applyStimulus(input int i);
    hand_vec_t v;
    int        nc;
    v  = vecs[i];
    nc = int'(v.n_cards);
    deck.delete();
    for (int c = 0; c < nc; c++) deck.push_back(v.cards[(nc-1-c)*4 +: 4]);
    start_hand();
    run_player({62'd0, v.cmd}, int'(v.n_cmds), int'(v.hold), 1'b0, $sformatf("vec%0d", i));
    check_hand($sformatf("vec%0d", i), int'(v.exp_p), int'(v.exp_d), int'(v.exp_res),
               nc, int'(v.n_cmds));
  endtask

  function automatic int pts(input int v);
    if (v >= 1 && v <= 10) return v;
    return 10;
  endfunction

  function automatic int best_of(input int sum, input bit ace);
    return (ace && sum + 10 <= 21) ? sum + 10 : sum;
  endfunction

  // Plays the hand on card values: player hits below thr, dealer draws below 17.
  task automatic model_hand(input int dk[40], input int thr, output logic [63:0] cmds,
                            output int n, output int used, output int ep, output int ed,
                            output int er);
    int ps, ds, idx, pb;
    bit pa, da;
    cmds = '0;
    n    = 0;
    ps   = pts(dk[0]) + pts(dk[2]);
    pa   = (dk[0] == 1) || (dk[2] == 1);
    ds   = pts(dk[1]) + pts(dk[3]);
    da   = (dk[1] == 1) || (dk[3] == 1);
    idx  = 4;
    while (best_of(ps, pa) < 21 && idx < 40 && n < 15) begin
      if (best_of(ps, pa) < thr) begin
        cmds[n*4 +: 4] = 4'(COMMAND_HIT);
        n++;
        ps += pts(dk[idx]);
        pa |= (dk[idx] == 1);
        idx++;
      end else begin
        cmds[n*4 +: 4] = 4'(COMMAND_STAND);
        n++;
        break;
      end
    end
    pb = best_of(ps, pa);
    if (pb <= 21) begin
      while (best_of(ds, da) < 17 && idx < 40) begin
        ds += pts(dk[idx]);
        da |= (dk[idx] == 1);
        idx++;
      end
    end
    ep   = pb;
    ed   = best_of(ds, da);
    used = idx;
    if (ep > 21)      er = 2;
    else if (ed > 21) er = 1;
    else if (ep > ed) er = 1;
    else if (ep < ed) er = 2;
    else              er = 3;
  endtask

  initial begin
    // cards (first dealt in the leftmost nibble), count, command, #commands, hold, P, D, result
    vecs[0] = '{32'h000A7985, 4'd5, 2'd2, 2'd1, 8'd2,    5'd19, 5'd20, 2'd2};
    vecs[1] = '{32'h00016DA2, 4'd5, 2'd0, 2'd0, 8'd1,    5'd21, 5'd18, 2'd1};
    vecs[2] = '{32'h000A968C, 4'd5, 2'd1, 2'd1, 8'(5*RC), 5'd26, 5'd17, 2'd2};
    vecs[3] = '{32'h0000A176, 4'd4, 2'd2, 2'd1, 8'd3,    5'd17, 5'd17, 2'd3};
    vecs[4] = '{32'h000AA66A, 4'd5, 2'd2, 2'd1, 8'd1,    5'd16, 5'd26, 2'd1};
    vecs[5] = '{32'h0000AAA8, 4'd4, 2'd2, 2'd1, 8'd4,    5'd20, 5'd18, 2'd1};
    vecs[6] = '{32'h00151597, 4'd6, 2'd1, 2'd1, 8'd2,    5'd21, 5'd17, 2'd1};
    vecs[7] = '{32'h000EF234, 4'd6, 2'd2, 2'd1, 8'd2,    5'd20, 5'd19, 2'd1};

    reset = 1'b1; start = 1'b0; player_ready = 1'b0; player_command = COMMAND_NONE;
    card_valid = 1'b0; card_value = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset card_req", int'(card_req), 0);
    checkOutput("reset turn_indicator", int'(turn_indicator), 0);
    checkOutput("reset totals", int'(player_total) + int'(dealer_total), 0);
    checkOutput("reset result", int'(result), 0);
    checkOutput("reset done", int'(done), 0);

    // Stray card_valid without a request, then a long-withheld card.
    accepted = 0;
    card_valid = 1'b1; card_value = 4'd10;
    repeat (3) @(negedge clk);
    card_valid = 1'b0;
    checkOutput("stray_valid total", int'(player_total), 0);
    checkOutput("stray_valid accepted", accepted, 0);
    deck.delete();
    start_hand();
    begin
      int budget;
      bit stable;
      budget = 0;
      while (!card_req && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (!card_req || player_total != 5'd0) stable = 1'b0;
        @(negedge clk);
      end
      checkOutput("withheld card_req_and_total_stable", int'(stable), 1);
    end
    card_valid = 1'b1; card_value = 4'd7;
    @(negedge clk);
    card_valid = 1'b0;
    checkOutput("withheld card_req_drop", int'(card_req), 0);
    checkOutput("withheld player_total", int'(player_total), 7);
    repeat (3) @(negedge clk);
    checkOutput("withheld single_accept", accepted, 1);
    deck = '{4'd10, 4'd10, 4'd8};
    server_en = 1'b1;
    run_player({62'd0, COMMAND_STAND}, 1, 2, 1'b0, "withheld");
    check_hand("withheld", 17, 18, 2, 4, 1);

    for (int i = 0; i < 8; i++) applyStimulus(i);

    // Reset while the dealer is waiting on a card.
    deck = '{4'd10, 4'd6, 4'd10, 4'd5};
    start_hand();
    run_player({62'd0, COMMAND_STAND}, 1, 2, 1'b0, "midreset");
    begin
      int budget;
      budget = 0;
      while (!card_req && budget < 4*RC) begin
        @(negedge clk);
        budget++;
      end
      checkOutput("midreset dealer_request", int'(card_req), 1);
    end
    reset = 1'b1;
    #1;
    checkOutput("midreset card_req", int'(card_req), 0);
    checkOutput("midreset player_total", int'(player_total), 0);
    checkOutput("midreset dealer_total", int'(dealer_total), 0);
    checkOutput("midreset done", int'(done), 0);
    checkOutput("midreset result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(0);

    for (int h = 0; h < 40; h++) begin
      int          dk[40];
      int          thr, n, used, ep, ed, er;
      logic [63:0] cmds;
      for (int i = 0; i < 40; i++) dk[i] = $urandom_range(0, 15);
      thr = $urandom_range(12, 21);
      model_hand(dk, thr, cmds, n, used, ep, ed, er);
      deck.delete();
      for (int i = 0; i < 40; i++) deck.push_back(4'(dk[i]));
      start_hand();
      run_player(cmds, n, $urandom_range(1, 3*RC), 1'b1, $sformatf("rand%0d", h));
      check_hand($sformatf("rand%0d", h), ep, ed, er, used, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/blackjack_turn_controller.md
Name: blackjack_turn_controller

Overview:
- Sequences one hand of blackjack: deals the opening cards and gates the player's turn.
- Consumes the player's decoded HIT/STAND commands and runs the dealer's draw-to-threshold turn, then resolves the winner.
- Sits between the userInput block (drives its turnIndicator; takes its ready/command) and the card source (request/valid handshake).
- Owns all running totals and the hand result.

Parameters:
- DEALER_STAND, 17, best total at or above which the dealer stops drawing. Dealer stands on soft totals too.
- RELEASE_CYCLES, 1000, consecutive cycles player_ready must be low before a new command is accepted. Range 1..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a hand; sampled only in IDLE or DONE
- player_ready  input  1  userInput ready: the player's turn is active and a key is down
- player_command  input  gameCommand  userInput command (COMMAND_NONE/HIT/STAND)
- card_valid  input  1  card source has card_value valid
- card_value  input  4  1 = ace; 2..10 = pip value; 11..13 = face (10); 0, 14, 15 count as 10
- card_req  output  1  request one card
- turn_indicator  output  1  high only while the player may choose
- player_total  output  5  player's best total
- dealer_total  output  5  dealer's best total
- result  output  2  0 = none, 1 = player wins, 2 = dealer wins, 3 = push
- done  output  1  hand resolved; result valid

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0. Hard totals, ace flags and release counter cleared. Reset mid-hand abandons the hand; card_req drops at once.
- Totals:
  - Each side keeps a 5-bit hard total (aces count 1) and an ace-seen flag.
  - Best total = hard + 10 if ace-seen and hard + 10 <= 21; otherwise best total = hard.
  - The maximum hard total is 31, so no overflow occurs. player_total and dealer_total show the best total and are registered.
- Card handshake:
  - card_req rises on entry to any DEAL/HIT state and holds until sampled card_valid.
  - The card is accepted on the cycle card_req && card_valid. card_req is low the next cycle.
  - card_valid with card_req low is ignored.
  - The totals update on the cycle after acceptance.
- States:
  - IDLE: start=1 -> clear totals, result, done -> DEAL_P1.
  - DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2. Each state advances on card acceptance and adds the card to the indicated side.
  - After DEAL_D2 -> EVAL_P.
  - EVAL_P: player best = 21 -> DEALER_TURN (auto-stand). Player best > 21 -> RESOLVE. Otherwise -> PLAYER_TURN.
  - PLAYER_TURN: turn_indicator=1. On player_ready=1:
    - HIT -> PLAYER_HIT.
    - STAND -> WAIT_RELEASE then DEALER_TURN.
    - NONE -> no action.
    - In all cases turn_indicator drops the next cycle.
  - PLAYER_HIT: request one card -> WAIT_RELEASE then EVAL_P.
  - WAIT_RELEASE: turn_indicator=0.
    - The counter increments each cycle player_ready=0 and clears to 0 on any cycle player_ready=1.
    - At count = RELEASE_CYCLES, exit to the pending target. A held key therefore never produces a repeat HIT.
  - DEALER_TURN: dealer best < DEALER_STAND -> DEALER_HIT; otherwise -> RESOLVE.
  - DEALER_HIT: accept one card -> DEALER_TURN.
  - RESOLVE (one cycle), evaluated in priority order:
    1. Player > 21 -> 2.
    2. Dealer > 21 -> 1.
    3. Player > dealer -> 1.
    4. Player < dealer -> 2.
    5. Equal -> 3.
  - RESOLVE then goes to DONE.
  - DONE: done=1 and result held. Totals held. start=1 -> as IDLE.
- start in any state other than IDLE or DONE is ignored.
- turn_indicator is registered and is 1 only in PLAYER_TURN. player_ready/command are ignored in all other states.

Test Plan:
- Reset, then start; cards 10,7,9,8 (P,D,P,D); player STAND pulse then release -> player_total=19, dealer_total=15. Dealer draws one card, 5 -> 20. result=2, done=1.
- Cards 1,6,13,10 -> player best 21 after DEAL_P2. EVAL_P auto-stands; turn_indicator never asserts. Dealer 16 draws 2 -> 18. result=1.
- Player 10,6 vs dealer 9,8. HIT held high for 5*RELEASE_CYCLES cycles with card 12 -> exactly one card_req. player_total=26, result=2, no dealer draw.
- Dealer 1,6 (soft 17), player 10,7, STAND -> dealer draws nothing. result=3.
- card_valid pulsed with card_req=0, then card_req held 20 cycles with card_valid low -> no total change until card_valid. Acceptance occurs exactly once.
- reset asserted during DEALER_HIT with card_req=1 -> same cycle: card_req=0, totals=0, done=0, state IDLE. New start deals correctly.
